// File: rtl/sersub_pkg.sv
// ---------------------------------------------------------------------------
// sersub_pkg
// Shared types and helpers for the serial subtractor slice.
//   sersub_state_t : controller states (IDLE, RUN, DONE)
//   cnt_width()    : step-counter width, $clog2(steps) with a floor of 1
// ---------------------------------------------------------------------------
package sersub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sersub_state_t;

  // A single-step operation still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/fs_cell.sv
// ---------------------------------------------------------------------------
// fs_cell
// Single-bit combinational full-subtract cell: computes x - y - bi.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
// ---------------------------------------------------------------------------
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Multi-cycle WIDTH-bit subtractor computing a - b - bin, DIGIT bits per
// cycle, through a registered borrow chain. Valid/ready on both sides.
//
// Parameters:
//   WIDTH : operand/result width (>= 1)
//   DIGIT : bits processed per cycle (must divide WIDTH)
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = state is IDLE)
//   a, b, bin           : minuend, subtrahend, borrow into bit 0
//   out_valid/out_ready : result handshake
//   diff                : (a - b - bin) mod 2^WIDTH
//   borrow              : borrow out of the MSB
//   ovf                 : signed overflow (only with SERSUB_SIGNED_EN)
//
// Optional feature macro: SERSUB_SIGNED_EN adds the ovf port and its logic.
// ---------------------------------------------------------------------------
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERSUB_SIGNED_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(STEPS);

  sersub_state_t   state;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_r;
  logic            brw;
  logic            out_valid_r;

  // Per-cycle ripple: chain[0] is the registered borrow, chain[DIGIT] the
  // borrow handed to the next step.
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] dig;

  assign chain[0] = brw;

  for (genvar g = 0; g < DIGIT; g++) begin : g_cell
    fs_cell u_cell (
      .x  (a_sr[g]),
      .y  (b_sr[g]),
      .bi (chain[g]),
      .d  (dig[g]),
      .bo (chain[g+1])
    );
  end

  logic             last_step;
  logic [WIDTH-1:0] diff_next;

  assign last_step = (cnt == CW'(STEPS - 1));
  // New digit enters at the top so that after STEPS shifts the first digit
  // computed sits at bit 0. Written with shifts so WIDTH == DIGIT needs no
  // empty slice.
  assign diff_next = (diff_r >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));

`ifdef SERSUB_SIGNED_EN
  logic ovf_r;
  logic ovf_next;
  // On the final step the top cell sees the operand MSBs; overflow is a sign
  // mismatch between the operands with the result sign differing from a's.
  assign ovf_next = (a_sr[DIGIT-1] != b_sr[DIGIT-1]) &&
                    (dig[DIGIT-1]  != a_sr[DIGIT-1]);
  assign ovf      = ovf_r;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign borrow    = brw;

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      diff_r      <= '0;
      brw         <= 1'b0;
      out_valid_r <= 1'b0;
`ifdef SERSUB_SIGNED_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          diff_r <= diff_next;
          brw    <= chain[DIGIT];
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
`ifdef SERSUB_SIGNED_EN
            ovf_r       <= ovf_next;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
// Three instances: k=0 WIDTH=8/DIGIT=1, k=1 WIDTH=1/DIGIT=1,
// k=2 WIDTH=16/DIGIT=4. A reference model tracks occupancy and expected
// results from plain arithmetic and is compared every cycle.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [3];
  logic        ordy [3];
  logic [15:0] a_k  [3];
  logic [15:0] b_k  [3];
  logic        bi_k [3];
  logic        ir   [3];
  logic        ov_v [3];
  logic        br_k [3];
  logic [7:0]  d0;
  logic        d1;
  logic [15:0] d2;
  logic [15:0] dk   [3];
`ifdef SERSUB_SIGNED_EN
  logic        ovf_k[3];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign dk[0] = {8'h00, d0};
  assign dk[1] = {15'h0000, d1};
  assign dk[2] = d2;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_k[0][7:0]), .b(b_k[0][7:0]), .bin(bi_k[0]),
    .out_valid(ov_v[0]), .out_ready(ordy[0]), .diff(d0), .borrow(br_k[0])
`ifdef SERSUB_SIGNED_EN
    , .ovf(ovf_k[0])
`endif
  );

  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_k[1][0:0]), .b(b_k[1][0:0]), .bin(bi_k[1]),
    .out_valid(ov_v[1]), .out_ready(ordy[1]), .diff(d1), .borrow(br_k[1])
`ifdef SERSUB_SIGNED_EN
    , .ovf(ovf_k[1])
`endif
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_k[2]), .b(b_k[2]), .bin(bi_k[2]),
    .out_valid(ov_v[2]), .out_ready(ordy[2]), .diff(d2), .borrow(br_k[2])
`ifdef SERSUB_SIGNED_EN
    , .ovf(ovf_k[2])
`endif
  );

  function automatic int w_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 1 : 16;
  endfunction

  function automatic int s_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 1 : 4;
  endfunction

  // Reference: unsigned and signed arithmetic on the operands.
  function automatic void model(input int w, input logic [15:0] av, bv,
                                input logic bi, output logic [15:0] d,
                                output logic br, output logic ov);
    longint m, ua, ub, r, half, sa, sb, rs;
    m    = (longint'(1) << w) - 1;
    ua   = longint'(av) & m;
    ub   = longint'(bv) & m;
    r    = ua - ub - longint'(bi);
    d    = 16'(r & m);
    br   = (r < 0);
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    rs   = sa - sb - longint'(bi);
    ov   = (rs < -half) || (rs > half - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model of occupancy and expected result ----------------
  int          cyc = 0;
  bit          busy [3];
  int          acc  [3];
  logic [15:0] e_d  [3];
  logic        e_br [3];
  logic        e_ov [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) busy[k] = 1'b0;
    end else begin
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (!busy[k]) begin
          if (iv[k]) begin
            busy[k] = 1'b1;
            acc[k]  = cyc;
            model(w_of(k), a_k[k], b_k[k], bi_k[k], e_d[k], e_br[k], e_ov[k]);
          end
        end else if ((cyc - 1 - acc[k]) >= s_of(k) && ordy[k]) begin
          busy[k] = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        check($sformatf("k%0d_rst_in_ready", k), 32'(ir[k]), 32'd1);
        check($sformatf("k%0d_rst_out_valid", k), 32'(ov_v[k]), 32'd0);
        check($sformatf("k%0d_rst_diff", k), 32'(dk[k]), 32'd0);
        check($sformatf("k%0d_rst_borrow", k), 32'(br_k[k]), 32'd0);
`ifdef SERSUB_SIGNED_EN
        check($sformatf("k%0d_rst_ovf", k), 32'(ovf_k[k]), 32'd0);
`endif
      end else begin
        logic ev;
        ev = busy[k] && ((cyc - acc[k]) >= s_of(k));
        check($sformatf("k%0d_in_ready", k), 32'(ir[k]), 32'(!busy[k]));
        check($sformatf("k%0d_out_valid", k), 32'(ov_v[k]), 32'(ev));
        if (ev) begin
          check($sformatf("k%0d_diff", k), 32'(dk[k]), 32'(e_d[k]));
          check($sformatf("k%0d_borrow", k), 32'(br_k[k]), 32'(e_br[k]));
`ifdef SERSUB_SIGNED_EN
          check($sformatf("k%0d_ovf", k), 32'(ovf_k[k]), 32'(e_ov[k]));
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input int k, input logic [15:0] av, bv, input logic bi,
                       output logic [15:0] d, output logic br, output logic ov,
                       output int lat);
    @(posedge clk); #1;
    a_k[k] = av; b_k[k] = bv; bi_k[k] = bi; iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = 0;
    while (!ov_v[k] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ov_v[k]) check($sformatf("k%0d_op_timeout", k), 32'(ov_v[k]), 32'd1);
    d  = dk[k];
    br = br_k[k];
`ifdef SERSUB_SIGNED_EN
    ov = ovf_k[k];
`else
    ov = 1'b0;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d, md;
    logic        br, ov, mbr, mov;
    int          lat;

    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b1; a_k[k] = '0; b_k[k] = '0; bi_k[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("reset_in_ready", 32'(ir[0]), 32'd1);
    check("reset_out_valid", 32'(ov_v[0]), 32'd0);
    check("reset_diff", 32'(d0), 32'd0);
    check("reset_borrow", 32'(br_k[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the model with hand-computed values.
    model(8, 16'h05, 16'h03, 1'b0, md, mbr, mov);
    check("model_5_3", {15'd0, mbr, md}, 32'h0002);
    model(8, 16'h10, 16'h10, 1'b1, md, mbr, mov);
    check("model_10_10_1", {15'd0, mbr, md}, 32'h100FF);
    model(8, 16'h80, 16'h01, 1'b0, md, mbr, mov);
    check("model_ovf", {15'd0, mov, md}, 32'h1007F);

    // Basic and borrow-out cases, WIDTH=8 DIGIT=1.
    do_op(0, 16'h05, 16'h03, 1'b0, d, br, ov, lat);
    check("basic_diff", 32'(d), 32'h02);
    check("basic_borrow", 32'(br), 32'd0);
    check("basic_latency", 32'(lat), 32'd8);
    do_op(0, 16'h00, 16'h01, 1'b0, d, br, ov, lat);
    check("b0_diff", 32'(d), 32'hFF);
    check("b0_borrow", 32'(br), 32'd1);
    do_op(0, 16'h10, 16'h10, 1'b1, d, br, ov, lat);
    check("b1_diff", 32'(d), 32'hFF);
    check("b1_borrow", 32'(br), 32'd1);
`ifdef SERSUB_SIGNED_EN
    do_op(0, 16'h80, 16'h01, 1'b0, d, br, ov, lat);
    check("sgn_diff", 32'(d), 32'h7F);
    check("sgn_ovf", 32'(ov), 32'd1);
`endif

    // Single-bit exhaustive.
    for (int i = 0; i < 8; i++) begin
      logic av, bv, bi;
      int   r;
      av = i[2]; bv = i[1]; bi = i[0];
      r  = int'(av) - int'(bv) - int'(bi);
      do_op(1, {15'd0, av}, {15'd0, bv}, bi, d, br, ov, lat);
      check($sformatf("w1_%0d_diff", i), 32'(d[0]), 32'(r & 1));
      check($sformatf("w1_%0d_borrow", i), 32'(br), 32'(r < 0));
      check($sformatf("w1_%0d_latency", i), 32'(lat), 32'd1);
      if (i == 5) check("w1_101", {30'd0, br, d[0]}, 32'b00);
      if (i == 3) check("w1_011", {30'd0, br, d[0]}, 32'b10);
    end

    // Backpressure: result held, in_valid ignored.
    ordy[0] = 1'b0;
    do_op(0, 16'h3C, 16'h5A, 1'b1, d, br, ov, lat);
    check("bp_diff0", 32'(d), 32'hE1);
    check("bp_borrow0", 32'(br), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      iv[0]  = ~iv[0];
      a_k[0] = 16'($urandom);
      b_k[0] = 16'($urandom);
      check("bp_diff", 32'(d0), 32'hE1);
      check("bp_borrow", 32'(br_k[0]), 32'd1);
      check("bp_in_ready", 32'(ir[0]), 32'd0);
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 32'(ir[0]), 32'd1);
    check("bp_release_valid", 32'(ov_v[0]), 32'd0);

    // Reset mid-RUN, then a clean operation.
    @(posedge clk); #1;
    a_k[0] = 16'h05; b_k[0] = 16'h03; bi_k[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(ov_v[0]), 32'd0);
    check("midrst_in_ready", 32'(ir[0]), 32'd1);
    check("midrst_diff", 32'(d0), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    do_op(0, 16'hA7, 16'h3B, 1'b1, d, br, ov, lat);
    check("post_rst_diff", 32'(d), 32'h6B);
    check("post_rst_borrow", 32'(br), 32'd0);

    // Random operands on WIDTH=8 and WIDTH=16/DIGIT=4.
    for (int i = 0; i < 100; i++) begin
      logic [15:0] av, bv;
      logic        bi;
      av = 16'($urandom); bv = 16'($urandom); bi = 1'($urandom);
      model(8, av, bv, bi, md, mbr, mov);
      do_op(0, av, bv, bi, d, br, ov, lat);
      check("r8_diff", 32'(d), 32'(md));
      check("r8_borrow", 32'(br), 32'(mbr));
      check("r8_latency", 32'(lat), 32'd8);
    end
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] av, bv;
      logic        bi;
      av = 16'($urandom); bv = 16'($urandom); bi = 1'($urandom);
      if (i < 4) begin
        av = (i[0]) ? 16'hFFFF : 16'h0000;
        bv = (i[1]) ? 16'hFFFF : 16'h0000;
      end
      model(16, av, bv, bi, md, mbr, mov);
      do_op(2, av, bv, bi, d, br, ov, lat);
      check("r16_diff", 32'(d), 32'(md));
      check("r16_borrow", 32'(br), 32'(mbr));
      check("r16_latency", 32'(lat), 32'd4);
`ifdef SERSUB_SIGNED_EN
      check("r16_ovf", 32'(ov), 32'(mov));
`endif
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
